// File: rtl/mpi_link_pkg.sv
// Shared types and helpers for the MPI link transmit path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mpi_link_pkg;

    localparam int CREDIT_CNT_W = 4;
    // Wide enough for the 1..16 channel range, so out-of-range returns stay visible.
    localparam int CH_IDX_W     = 4;
    localparam int CREDIT_W     = 8;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;
    typedef logic [CREDIT_W-1:0] credit_t;

    // $clog2 that never returns zero, so single-channel builds still get a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mpi_chan_fifo.sv
// Per-channel synchronous FIFO holding producer words until the arbiter takes them.
// Latency: a pushed word is visible at head one cycle after the push edge.
// Backpressure: push is dropped while full unless a pop happens in the same cycle.
module mpi_chan_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array: contents are not reset, validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mpi_credit_tx.sv
// Multi-channel credit-flow-controlled transmit endpoint: per-channel FIFOs, round-robin grant, registered beat.
// Latency: word pushed at edge N into an idle, credited channel appears on link_valid after edge N+1.
// Backpressure: beat holds while !link_ready; channels without remote credit are skipped; in_ready drops when a FIFO is full.
module mpi_credit_tx
    import mpi_link_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int INIT_CREDIT = 4,
    parameter int MAX_CREDIT  = 15,
    parameter int RANK_W      = 32,
    localparam int CH_W       = clog2_min1(NUM_CH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RANK_W-1:0]        dest_rank,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     link_valid,
    input  logic                     link_ready,
    output logic [DATA_W-1:0]        link_data,
    output logic [CH_W-1:0]          link_ch,
    output logic [RANK_W-1:0]        link_dest,
    input  logic                     credit_valid,
    input  ch_idx_t                  credit_ch,
    input  logic [CREDIT_CNT_W-1:0]  credit_cnt,
    output logic                     credit_err
);

    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] elig;
    logic [CNT_W-1:0]  fifo_cnt  [NUM_CH];
    logic [DATA_W-1:0] fifo_head [NUM_CH];
    credit_t           credit     [NUM_CH];
    credit_t           credit_nxt [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_ch;
    logic              gnt_any;
    logic              grant;
    logic              cr_ovf;
    logic              bad_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mpi_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in_valid[c] && !fifo_full[c]),
            .push_data (in_data[c*DATA_W +: DATA_W]),
            .pop       (pop[c]),
            .full      (fifo_full[c]),
            .empty     (fifo_empty[c]),
            .count     (fifo_cnt[c]),
            .head      (fifo_head[c])
        );
        assign in_ready[c] = (fifo_cnt[c] < CNT_W'(FIFO_DEPTH));
        assign elig[c]     = !fifo_empty[c] && (credit[c] != '0);
        assign pop[c]      = grant && (gnt_ch == CH_W'(c));
    end

    // The output register may be reloaded when empty or draining this cycle.
    assign grant  = gnt_any && (!link_valid || link_ready);
    assign bad_ch = credit_valid && (int'(credit_ch) >= NUM_CH);

    // Round-robin search from rr_ptr; lowest offset from the pointer wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (elig[idx[CH_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx[CH_W-1:0];
            end
        end
    end

    // Credit update: grant costs one, a return adds cnt; saturate and flag overflow.
    always_comb begin
        int sum;
        sum    = 0;
        cr_ovf = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum = int'(credit[c]);
            if (grant && (gnt_ch == CH_W'(c))) sum = sum - 1;
            if (credit_valid && (credit_ch == ch_idx_t'(c))) sum = sum + int'(credit_cnt);
            if (sum > MAX_CREDIT) begin
                sum    = MAX_CREDIT;
                cr_ovf = 1'b1;
            end
            credit_nxt[c] = credit_t'(sum);
        end
    end

    // Credit counters and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) credit[c] <= credit_t'(INIT_CREDIT);
            credit_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) credit[c] <= credit_nxt[c];
            if (cr_ovf || bad_ch) credit_err <= 1'b1;
        end
    end

    // Pointer moves to the channel after the winner, only when a grant happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + CH_W'(1);
        end
    end

    // Output beat register; payload holds while the transport stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_data  <= '0;
            link_ch    <= '0;
            link_dest  <= '0;
        end else begin
            link_dest <= dest_rank;
            if (grant) begin
                link_valid <= 1'b1;
                link_ch    <= gnt_ch;
                link_data  <= fifo_head[gnt_ch];
            end else if (link_ready) begin
                link_valid <= 1'b0;
            end
        end
    end

endmodule
